// File: rtl/regfile_param.sv
// Parametrised register file: one write port, two registered read ports with
// write-first bypass, optional hardwired zero entry and a sequential clear engine.
module regfile_param #(
  parameter int WIDTH    = 4,
  parameter int ADDR_W   = 4,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [WIDTH-1:0]  rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [WIDTH-1:0]  rdata2,
  input  logic              clr_req,
  output logic              busy,
  output logic              wr_drop
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [WIDTH-1:0]  rdata1_q, rdata1_d;
  logic [WIDTH-1:0]  rdata2_q, rdata2_d;
  logic              wr_drop_q, wr_drop_d;
  logic              start_clr, blocked, wr_ok;

  // The entry edge (IDLE with clr_req) already blocks writes and reads.
  assign start_clr = (state_q == IDLE) && clr_req;
  assign blocked   = (state_q == CLEAR) || start_clr;
  assign wr_ok     = we && !blocked && !(ZERO_REG && (waddr == '0));

  function automatic logic [WIDTH-1:0] rd_sel(
    input logic              re,
    input logic [ADDR_W-1:0] raddr,
    input logic [WIDTH-1:0]  entry,
    input logic [WIDTH-1:0]  prev
  );
    if (!re)                              return prev;
    if (blocked)                          return '0;
    if (ZERO_REG && (raddr == '0))        return '0;
    if (wr_ok && (raddr == waddr))        return wdata;
    return entry;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mem_q     <= '{default: '0};
      rdata1_q  <= '0;
      rdata2_q  <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_q     <= mem_d;
      rdata1_q  <= rdata1_d;
      rdata2_q  <= rdata2_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (state_q == CLEAR) mem_d[cnt_q] = '0;
    else if (wr_ok)       mem_d[waddr] = wdata;
    rdata1_d  = rd_sel(re1, raddr1, mem_q[raddr1], rdata1_q);
    rdata2_d  = rd_sel(re2, raddr2, mem_q[raddr2], rdata2_q);
    wr_drop_d = we && blocked;
  end

  always_comb begin
    busy    = (state_q == CLEAR);
    rdata1  = rdata1_q;
    rdata2  = rdata2_q;
    wr_drop = wr_drop_q;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: a plain instance and a ZERO_REG instance share one
// stimulus stream and are each checked against an array-level reference model.
module tb_regfile_param;

  localparam int W  = 4;
  localparam int AW = 4;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          we, re1, re2, clr_req;
  logic [AW-1:0] waddr, raddr1, raddr2;
  logic [W-1:0]  wdata;
  logic [W-1:0]  rd1_a, rd2_a, rd1_b, rd2_b;
  logic          busy_a, drop_a, busy_b, drop_b;

  int n_cmp = 0;
  int n_err = 0;

  // Model: index 0 = ZERO_REG 0 instance, index 1 = ZERO_REG 1 instance.
  logic [W-1:0] m_mem [2][D];
  logic [W-1:0] m_rd1 [2];
  logic [W-1:0] m_rd2 [2];
  logic         m_drop [2];
  int           m_left [2];

  always #5 clk = ~clk;

  regfile_param #(.WIDTH(W), .ADDR_W(AW), .ZERO_REG(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rd1_a),
    .re2(re2), .raddr2(raddr2), .rdata2(rd2_a),
    .clr_req(clr_req), .busy(busy_a), .wr_drop(drop_a)
  );

  regfile_param #(.WIDTH(W), .ADDR_W(AW), .ZERO_REG(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rd1_b),
    .re2(re2), .raddr2(raddr2), .rdata2(rd2_b),
    .clr_req(clr_req), .busy(busy_b), .wr_drop(drop_b)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int z = 0; z < 2; z++) begin
      for (int i = 0; i < D; i++) m_mem[z][i] = '0;
      m_rd1[z] = '0; m_rd2[z] = '0; m_drop[z] = 1'b0; m_left[z] = 0;
    end
  endtask

  function automatic logic [W-1:0] model_read(input int z, input logic [AW-1:0] ra);
    if (z == 1 && ra == 0) return '0;
    if (we && !(z == 1 && waddr == 0) && ra == waddr) return wdata;
    return m_mem[z][ra];
  endfunction

  // A clear is observably the array going to zero at once, with reads giving
  // 0 and writes dropped for the next 16 edges.
  task automatic model_edge();
    for (int z = 0; z < 2; z++) begin
      if (m_left[z] > 0 || clr_req) begin
        if (m_left[z] == 0) begin
          m_left[z] = D;
          for (int i = 0; i < D; i++) m_mem[z][i] = '0;
        end else begin
          m_left[z]--;
        end
        m_drop[z] = we;
        if (re1) m_rd1[z] = '0;
        if (re2) m_rd2[z] = '0;
      end else begin
        if (re1) m_rd1[z] = model_read(z, raddr1);
        if (re2) m_rd2[z] = model_read(z, raddr2);
        if (we && !(z == 1 && waddr == 0)) m_mem[z][waddr] = wdata;
        m_drop[z] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    chk("a_rdata1", rd1_a, m_rd1[0]);
    chk("a_rdata2", rd2_a, m_rd2[0]);
    chk("a_busy", {3'b0, busy_a}, {3'b0, m_left[0] > 0});
    chk("a_wr_drop", {3'b0, drop_a}, {3'b0, m_drop[0]});
    chk("b_rdata1", rd1_b, m_rd1[1]);
    chk("b_rdata2", rd2_b, m_rd2[1]);
    chk("b_busy", {3'b0, busy_b}, {3'b0, m_left[1] > 0});
    chk("b_wr_drop", {3'b0, drop_b}, {3'b0, m_drop[1]});
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_in();
    we = 0; waddr = '0; wdata = '0; re1 = 0; raddr1 = '0;
    re2 = 0; raddr2 = '0; clr_req = 0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    idle_in(); we = 1; waddr = a; wdata = d; step();
  endtask

  initial begin
    int busy_cnt;
    int drop_cnt;
    idle_in();

    // Reset and idle
    #2 rst_n = 1'b0;
    #1 model_reset(); check_all();
    #10 rst_n = 1'b1;
    wr(3, 4'h5);
    idle_in(); re1 = 1; raddr1 = 3; step();
    chk("plan_rd3", rd1_a, 4'h5);
    chk("plan_rd2_idle", rd2_a, 4'h0);

    // Bypass
    wr(6, 4'h2);
    idle_in(); we = 1; waddr = 7; wdata = 4'hA;
    re1 = 1; raddr1 = 7; re2 = 1; raddr2 = 6; step();
    chk("plan_bypass1", rd1_a, 4'hA);
    chk("plan_bypass2", rd2_a, 4'h2);

    // Zero register
    wr(0, 4'hF);
    idle_in(); we = 1; waddr = 0; wdata = 4'hF;
    re1 = 1; raddr1 = 0; re2 = 1; raddr2 = 0; step();
    chk("plan_zero1", rd1_b, 4'h0);
    chk("plan_zero2", rd2_b, 4'h0);
    chk("plan_zero_drop", {3'b0, drop_b}, 4'h0);

    // Clear timing, with writes and a second request while busy
    for (int i = 0; i < D; i++) wr(AW'(i), 4'hC);
    idle_in(); clr_req = 1; step();
    busy_cnt = busy_a ? 1 : 0;
    drop_cnt = 0;
    for (int c = 1; c < 40 && busy_a; c++) begin
      idle_in();
      re1 = 1; raddr1 = AW'($urandom_range(0, D - 1));
      re2 = 1; raddr2 = 2;
      if (c == 3 || c == 5) begin we = 1; waddr = 2; wdata = 4'h9; end
      if (c == 7) clr_req = 1;
      step();
      if (busy_a) busy_cnt++;
      if (drop_a) drop_cnt++;
    end
    chk("plan_busy_len", 4'(busy_cnt), 4'(D));
    chk("plan_drop_cnt", 4'(drop_cnt), 4'd2);
    for (int i = 0; i < D; i += 2) begin
      idle_in(); re1 = 1; raddr1 = AW'(i); re2 = 1; raddr2 = AW'(i + 1); step();
      chk("plan_clr_rd1", rd1_a, 4'h0);
      chk("plan_clr_rd2", rd2_a, 4'h0);
    end

    // Reset mid-clear
    for (int i = 0; i < D; i++) wr(AW'(i), 4'(i + 1));
    idle_in(); clr_req = 1; step();
    idle_in();
    for (int c = 0; c < 4; c++) step();
    #2 rst_n = 1'b0;
    #1 model_reset(); check_all();
    chk("plan_rst_busy", {3'b0, busy_a}, 4'h0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < D; i++) begin
      idle_in(); re1 = 1; raddr1 = AW'(i); step();
    end
    wr(4, 4'h3);
    idle_in(); re2 = 1; raddr2 = 4; step();
    chk("plan_rst_wr4", rd2_a, 4'h3);

    // Randomised traffic
    for (int c = 0; c < 600; c++) begin
      we      = ($urandom_range(0, 1) == 1);
      waddr   = AW'($urandom_range(0, D - 1));
      wdata   = W'($urandom);
      re1     = ($urandom_range(0, 2) != 0);
      raddr1  = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, D - 1));
      re2     = ($urandom_range(0, 2) != 0);
      raddr2  = ($urandom_range(0, 5) == 0) ? AW'(0) : AW'($urandom_range(0, D - 1));
      clr_req = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the team's 16x4 register file.
- Provides configurable width and depth, one write port and two independent read ports.
- Read outputs are registered, with write-to-read bypass and an optional hardwired zero register.
- A sequential clear engine wipes the array on request. The block sits between the switch/rotary front-end decode and the display/ALU datapath.

Parameters:
- WIDTH, 4, data width of each entry in bits.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 0, when 1 entry 0 always reads 0 and ignores writes.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- we  input  1  write enable.
- waddr  input  ADDR_W  write address.
- wdata  input  WIDTH  write data.
- re1  input  1  read enable, port 1.
- raddr1  input  ADDR_W  read address, port 1.
- rdata1  output  WIDTH  registered read data, port 1.
- re2  input  1  read enable, port 2.
- raddr2  input  ADDR_W  read address, port 2.
- rdata2  output  WIDTH  registered read data, port 2.
- clr_req  input  1  start a full-array clear (level sampled each cycle).
- busy  output  1  high while the clear engine runs.
- wr_drop  output  1  one-cycle pulse when a write is discarded.

Behaviour:
- **Reset:** rst_n low asynchronously forces:
  - every array entry to 0;
  - rdata1 = rdata2 = 0, busy = 0, wr_drop = 0;
  - clear counter = 0, FSM = IDLE.
  - Reset asserted mid-clear aborts the clear; after release the FSM is IDLE.
- **Write:** in IDLE, we = 1 writes wdata to entry waddr at the rising edge.
  - If ZERO_REG = 1 and waddr = 0, the write is ignored. This is not a drop; wr_drop stays 0.
- **Read latency:** 1 cycle. If reN = 1 at edge k, rdataN holds the entry value visible from edge k onward. If reN = 0, rdataN holds its previous value.
- **Bypass (write-first):** if we = 1, a write is accepted, reN = 1 and raddrN = waddr in the same cycle, then rdataN gets wdata, not the old entry.
  - No bypass on port N when ZERO_REG = 1 and the address is 0; that read returns 0.
- **Zero register:** with ZERO_REG = 1, a read of address 0 always returns 0.
- **Simultaneous reads:** both ports may read the same or different addresses in the same cycle with no interaction.
- **FSM:** two states, IDLE and CLEAR.
  - IDLE -> CLEAR on a clock edge with clr_req = 1. busy goes high from that edge and the counter is loaded with 0.
  - In CLEAR, each edge writes 0 to entry[counter] and increments the counter. The last entry is DEPTH-1.
  - The edge that writes DEPTH-1 returns the FSM to IDLE, and busy drops at that edge.
  - busy is therefore high for exactly DEPTH cycles. The counter wraps to 0.
  - clr_req during CLEAR is ignored; no restart and no queueing.
  - clr_req still high on return to IDLE starts a new clear on the next edge.
- **Writes during CLEAR:**
  - we = 1 while busy is high (including the entry edge, where clr_req has priority over we) is discarded.
  - wr_drop pulses high for the following cycle, one pulse per discarded write.
  - The array is not modified by the write.
- **Reads during CLEAR:** reN = 1 while busy is high, or on the entry edge, loads rdataN with 0. There is no bypass during CLEAR.
- **Arithmetic:** the counter is ADDR_W bits and addresses are unsigned. Out-of-range addresses do not exist because DEPTH = 2**ADDR_W.

Test Plan:
- **Reset and idle:** defaults, pulse rst_n low, write 0x5 to addr 3, then re1 = 1 raddr1 = 3 -> rdata1 = 0x5 one edge after the read; rdata2 stays 0.
- **Bypass:** we = 1 waddr = 7 wdata = 0xA together with re1 = 1 raddr1 = 7 and re2 = 1 raddr2 = 6 (6 holds 0x2) -> next edge rdata1 = 0xA, rdata2 = 0x2.
- **Zero register:** ZERO_REG = 1, write 0xF to addr 0, read addr 0 on both ports with a same-cycle write of 0xF to addr 0 -> rdata1 = rdata2 = 0, wr_drop = 0.
- **Clear timing:** fill all 16 entries with 0xC, pulse clr_req for one cycle -> busy high for exactly 16 cycles. Reads during busy return 0; afterwards every address reads 0.
- **Writes and requests during clear:** during busy, issue we = 1 waddr = 2 wdata = 0x9 on two cycles and a second clr_req -> two wr_drop pulses, busy still exactly 16 cycles, addr 2 reads 0 after the clear.
- **Reset mid-clear:** assert rst_n low at clear cycle 5 -> busy = 0 immediately, all entries 0. After release a write to addr 4 of 0x3 succeeds and reads back 0x3.
